// File: rtl/i2c_reg_writer.sv
// I2C master that writes y0, y1, speed and trig to consecutive slave registers
// starting at pointer 0x00, using one auto-increment write transaction per start.
module i2c_reg_writer #(
    parameter int          CLK_FREQ   = 100_000_000,
    parameter int          I2C_FREQ   = 100_000,
    parameter logic [6:0]  SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] y0,
    input  logic [7:0] y1,
    input  logic [7:0] speed,
    input  logic [7:0] trig,
    output logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    // QTR must be at least 2 for the quarter counter to make sense.
    localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        DONE
    } state_t;

    state_t          state_q;
    logic [QW-1:0]   qCnt_q;
    logic [1:0]      phase_q;
    logic [2:0]      bitIdx_q;
    logic [2:0]      byteIdx_q;
    logic [5:0][7:0] bytes_q;
    logic            nack_q;
    logic            scl_q;
    logic            sdaLow_q;
    logic            busy_q;
    logic            done_q;
    logic            ackErr_q;
    logic            tick_d;

    assign tick_d = busy_q && (qCnt_q == QW'(QTR - 1));

    // Each tick ends the current quarter; the outputs for the next quarter are
    // registered on that same edge so SCL/SDA only ever move on ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            qCnt_q    <= '0;
            phase_q   <= 2'd0;
            bitIdx_q  <= 3'd7;
            byteIdx_q <= 3'd0;
            bytes_q   <= '0;
            nack_q    <= 1'b0;
            scl_q     <= 1'b1;
            sdaLow_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ackErr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                qCnt_q <= tick_d ? '0 : qCnt_q + QW'(1);
            end
            case (state_q)
                IDLE: begin
                    scl_q    <= 1'b1;
                    sdaLow_q <= 1'b0;
                    if (start) begin
                        bytes_q   <= {trig, speed, y1, y0, 8'h00, {SLAVE_ADDR, 1'b0}};
                        ackErr_q  <= 1'b0;
                        state_q   <= START;
                        phase_q   <= 2'd0;
                        bitIdx_q  <= 3'd7;
                        byteIdx_q <= 3'd0;
                        busy_q    <= 1'b1;
                        qCnt_q    <= '0;
                    end
                end
                START: begin
                    if (tick_d) begin
                        if (phase_q == 2'd0) begin
                            sdaLow_q <= 1'b1;
                            phase_q  <= 2'd1;
                        end else begin
                            state_q  <= BIT;
                            phase_q  <= 2'd0;
                            bitIdx_q <= 3'd7;
                            scl_q    <= 1'b0;
                            sdaLow_q <= ~bytes_q[0][7];
                        end
                    end
                end
                BIT: begin
                    if (tick_d) begin
                        case (phase_q)
                            2'd0: phase_q <= 2'd1;
                            2'd1: begin
                                phase_q <= 2'd2;
                                scl_q   <= 1'b1;
                            end
                            2'd2: phase_q <= 2'd3;
                            default: begin
                                phase_q <= 2'd0;
                                scl_q   <= 1'b0;
                                if (bitIdx_q == 3'd0) begin
                                    state_q  <= ACK;
                                    sdaLow_q <= 1'b0;
                                end else begin
                                    bitIdx_q <= bitIdx_q - 3'd1;
                                    sdaLow_q <= ~bytes_q[byteIdx_q][bitIdx_q - 3'd1];
                                end
                            end
                        endcase
                    end
                end
                ACK: begin
                    if (tick_d) begin
                        case (phase_q)
                            2'd0: phase_q <= 2'd1;
                            2'd1: begin
                                phase_q <= 2'd2;
                                scl_q   <= 1'b1;
                            end
                            2'd2: begin
                                phase_q <= 2'd3;
                                nack_q  <= SDA;
                            end
                            default: begin
                                phase_q <= 2'd0;
                                scl_q   <= 1'b0;
                                if (nack_q || byteIdx_q == 3'd5) begin
                                    ackErr_q <= ackErr_q | nack_q;
                                    state_q  <= STOP;
                                    sdaLow_q <= 1'b1;
                                end else begin
                                    state_q   <= BIT;
                                    byteIdx_q <= byteIdx_q + 3'd1;
                                    bitIdx_q  <= 3'd7;
                                    sdaLow_q  <= ~bytes_q[byteIdx_q + 3'd1][7];
                                end
                            end
                        endcase
                    end
                end
                STOP: begin
                    if (tick_d) begin
                        case (phase_q)
                            2'd0: begin
                                phase_q <= 2'd1;
                                scl_q   <= 1'b1;
                            end
                            2'd1: begin
                                phase_q  <= 2'd2;
                                sdaLow_q <= 1'b0;
                            end
                            default: begin
                                phase_q <= 2'd0;
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SDA     = sdaLow_q ? 1'b0 : 1'bz;
    assign SCL     = scl_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ackErr_q;

endmodule
